// File: rtl/wavetable_nco.sv
// wavetable_nco: tick-driven NCO that reads a 256-entry offset-binary sine ROM and emits signed samples.
// Define NCO_GAIN_EN to add an 8-bit gain port (128 = unity) with saturation at the output.
module wavetable_nco #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [PHASE_W-1:0] tuning_word,
    input  logic               phase_clr,
`ifdef NCO_GAIN_EN
    input  logic [7:0]         gain,
`endif
    output logic               rom_en,
    output logic [8:0]         rom_addr,
    input  logic [15:0]        rom_dout,
    output logic [15:0]        sample,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun
);
    typedef enum logic [1:0] {IDLE, REQ, CAPT, HOLD} state_t;
    state_t state;
    logic [PHASE_W-1:0] phase;
    logic [15:0] rom_signed, cap_val;
    assign rom_signed = {~rom_dout[15], rom_dout[14:0]};
`ifdef NCO_GAIN_EN
    logic signed [24:0] s_ext, g_ext, prod, scaled;
    // Scale by gain/128 and clamp to the 16-bit signed range.
    always_comb begin
        s_ext   = {{9{rom_signed[15]}}, rom_signed};
        g_ext   = {17'd0, gain};
        prod    = s_ext * g_ext;
        scaled  = prod >>> 7;
        cap_val = (scaled > 25'sd32767) ? 16'h7fff : (scaled < -25'sd32768) ? 16'h8000 : scaled[15:0];
    end
`else
    assign cap_val = rom_signed;
`endif
    // Phase advances on every tick, accepted or dropped; a clear restarts accumulation from zero.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) phase <= '0;
        else if (tick) phase <= (phase_clr ? '0 : phase) + tuning_word;
        else if (phase_clr) phase <= '0;
    // Read sequencer: one ROM read per accepted tick, capture, then hold until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rom_en       <= 1'b0;
            rom_addr     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    rom_addr <= {1'b0, phase_clr ? 8'd0 : phase[PHASE_W-1 -: 8]};
                    rom_en   <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    rom_en <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    sample       <= cap_val;
                    sample_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: if (sample_ready) begin
                    sample_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wavetable_nco.sv
// tb_wavetable_nco: randomized self-checking bench for wavetable_nco with an external registered ROM model.
module tb_wavetable_nco;
    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, phase_clr = 1'b0, sample_ready = 1'b1;
    logic [31:0] tuning_word = '0;
    logic rom_en, sample_valid, overrun;
    logic [8:0] rom_addr;
    logic [15:0] rom_dout = '0, sample;
`ifdef NCO_GAIN_EN
    logic [7:0] gain = 8'd128;
`endif
    logic [15:0] rom [256];
    logic [31:0] mphase = '0;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr[7:0]];

    wavetable_nco #(.PHASE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tuning_word(tuning_word), .phase_clr(phase_clr),
`ifdef NCO_GAIN_EN
        .gain(gain),
`endif
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout), .sample(sample),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
    );

    function automatic logic [15:0] exp_sample(input logic [7:0] i);
        int v;
        v = int'(rom[i]) - 32768;
`ifdef NCO_GAIN_EN
        v = (v * int'(gain)) >>> 7;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return 16'(v);
    endfunction

    task automatic do_tick(input bit clr, output logic [7:0] idx);
        idx = clr ? 8'd0 : mphase[31:24];
        mphase = clr ? tuning_word : mphase + tuning_word;
        tick = 1'b1;
        phase_clr = clr;
        @(negedge clk);
        tick = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mphase = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got %b exp 0", rom_en); end
        n_checks++; if (rom_addr !== 9'd0) begin n_fail++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
        n_checks++; if (sample !== 16'd0) begin n_fail++; $display("FAIL reset_sample got %h exp 0", sample); end
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", sample_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] idx;
        int want [4];
        want = '{130, 32253, -645, -32768};
        tuning_word = 32'h4000_0000;
        sample_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_tick(1'b0, idx);
            n_checks++; if (rom_en !== 1'b1 || rom_addr !== 9'(k * 64)) begin n_fail++; $display("FAIL basic_addr k=%0d got en=%b addr=%0d exp en=1 addr=%0d", k, rom_en, rom_addr, k * 64); end
            @(negedge clk);
            n_checks++; if (rom_en !== 1'b0 || sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_req k=%0d got en=%b valid=%b exp 0 0", k, rom_en, sample_valid); end
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1 || sample !== 16'(want[k])) begin n_fail++; $display("FAIL basic_sample k=%0d got valid=%b sample=%0d exp 1 %0d", k, sample_valid, $signed(sample), want[k]); end
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop k=%0d got valid=%b exp 0", k, sample_valid); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] idx;
        tuning_word = 32'h0100_0000;
        for (int k = 0; k < 260; k++) begin
            do_tick(1'b0, idx);
            n_checks++; if (rom_en !== 1'b1 || rom_addr !== {1'b0, idx}) begin n_fail++; $display("FAIL sweep_addr k=%0d got en=%b addr=%h exp 1 %h", k, rom_en, rom_addr, {1'b0, idx}); end
            @(negedge clk);
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1 || sample !== exp_sample(idx)) begin n_fail++; $display("FAIL sweep_sample k=%0d got %b %h exp 1 %h", k, sample_valid, sample, exp_sample(idx)); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] idx;
        int delay;
        for (int k = 0; k < 40; k++) begin
            tuning_word = $urandom;
            delay = $urandom_range(0, 3);
            sample_ready = (delay == 0);
`ifdef NCO_GAIN_EN
            gain = 8'($urandom);
`endif
            do_tick(1'b0, idx);
            n_checks++; if (rom_addr !== {1'b0, idx}) begin n_fail++; $display("FAIL rand_addr k=%0d got %h exp %h", k, rom_addr, {1'b0, idx}); end
            @(negedge clk);
            @(negedge clk);
            repeat (delay) @(negedge clk);
            n_checks++; if (sample_valid !== 1'b1 || sample !== exp_sample(idx)) begin n_fail++; $display("FAIL rand_sample k=%0d got %b %h exp 1 %h", k, sample_valid, sample, exp_sample(idx)); end
            sample_ready = 1'b1;
            @(negedge clk);
            n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drop k=%0d got %b exp 0", k, sample_valid); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
`ifdef NCO_GAIN_EN
        gain = 8'd128;
`endif
    endtask

    task automatic test_clr;
        logic [7:0] idx;
        tuning_word = 32'h1000_0000;
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        mphase = '0;
        for (int k = 0; k < 10; k++) begin
            do_tick(k == 8, idx);
            n_checks++; if (rom_addr !== {1'b0, idx}) begin n_fail++; $display("FAIL clr_addr k=%0d got %h exp %h", k, rom_addr, {1'b0, idx}); end
            if (k == 8) begin
                n_checks++; if (rom_addr !== 9'h000) begin n_fail++; $display("FAIL clr_tick_addr got %h exp 000", rom_addr); end
            end
            if (k == 9) begin
                n_checks++; if (rom_addr !== 9'h010) begin n_fail++; $display("FAIL clr_next_addr got %h exp 010", rom_addr); end
            end
            @(negedge clk);
            @(negedge clk);
            n_checks++; if (sample !== exp_sample(idx)) begin n_fail++; $display("FAIL clr_sample k=%0d got %h exp %h", k, sample, exp_sample(idx)); end
            @(negedge clk);
        end
    endtask

    task automatic test_hold_overrun;
        logic [7:0] idx, dropped;
        logic [15:0] held;
        bit stable;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL hold_pre_overrun got %b exp 0", overrun); end
        tuning_word = $urandom;
        sample_ready = 1'b0;
        do_tick(1'b0, idx);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b1 || sample !== exp_sample(idx)) begin n_fail++; $display("FAIL hold_first got %b %h exp 1 %h", sample_valid, sample, exp_sample(idx)); end
        held = exp_sample(idx);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) do_tick(1'b0, dropped);
            else @(negedge clk);
            if (sample !== held || sample_valid !== 1'b1 || rom_en !== 1'b0) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable got %b exp 1", stable); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL hold_overrun got %b exp 1", overrun); end
        sample_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b exp 0", sample_valid); end
        do_tick(1'b0, idx);
        n_checks++; if (rom_addr !== {1'b0, idx}) begin n_fail++; $display("FAIL hold_phase got %h exp %h", rom_addr, {1'b0, idx}); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sample !== exp_sample(idx)) begin n_fail++; $display("FAIL hold_next_sample got %h exp %h", sample, exp_sample(idx)); end
        @(negedge clk);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL hold_sticky got %b exp 1", overrun); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] idx;
        bit seen;
        tuning_word = 32'h0300_0000;
        do_tick(1'b0, idx);
        rst_n = 1'b0;
        #1;
        mphase = '0;
        n_checks++; if (rom_en !== 1'b0 || sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got en=%b valid=%b exp 0 0", rom_en, sample_valid); end
        n_checks++; if (overrun !== 1'b0 || rom_addr !== 9'd0) begin n_fail++; $display("FAIL rstmid_clear got ovr=%b addr=%h exp 0 0", overrun, rom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_novalid got %b exp 0", seen); end
        sample_ready = 1'b0;
        do_tick(1'b0, idx);
        n_checks++; if (rom_addr !== 9'd0) begin n_fail++; $display("FAIL rst_first_addr got %h exp 000", rom_addr); end
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b1 || sample !== exp_sample(8'd0)) begin n_fail++; $display("FAIL rsthold_pre got %b %h exp 1 %h", sample_valid, sample, exp_sample(8'd0)); end
        rst_n = 1'b0;
        #1;
        mphase = '0;
        n_checks++; if (sample_valid !== 1'b0 || sample !== 16'd0) begin n_fail++; $display("FAIL rsthold_async got %b %h exp 0 0000", sample_valid, sample); end
        @(negedge clk);
        rst_n = 1'b1;
        sample_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rsthold_novalid got seen=%b ovr=%b exp 0 0", seen, overrun); end
        do_tick(1'b0, idx);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sample_valid !== 1'b1 || sample !== exp_sample(idx)) begin n_fail++; $display("FAIL rst_resume got %b %h exp 1 %h", sample_valid, sample, exp_sample(idx)); end
        @(negedge clk);
    endtask

`ifdef NCO_GAIN_EN
    task automatic test_gain;
        logic [7:0] idx;
        logic [7:0] g [4];
        g = '{8'd128, 8'd255, 8'd128, 8'd64};
        rst_n = 1'b0;
        mphase = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tuning_word = 32'h4000_0000;
        for (int k = 0; k < 4; k++) begin
            gain = g[k];
            do_tick(1'b0, idx);
            @(negedge clk);
            @(negedge clk);
            n_checks++; if (sample !== exp_sample(idx)) begin n_fail++; $display("FAIL gain_model k=%0d got %h exp %h", k, sample, exp_sample(idx)); end
            if (k == 1) begin
                n_checks++; if (sample !== 16'h7fff) begin n_fail++; $display("FAIL gain_sat got %h exp 7fff", sample); end
            end
            if (k == 3) begin
                n_checks++; if (sample !== 16'hc000) begin n_fail++; $display("FAIL gain_half got %h exp c000", sample); end
            end
            @(negedge clk);
        end
        gain = 8'd128;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0]   = 16'h8082;
        rom[64]  = 16'hfdfd;
        rom[128] = 16'h7d7b;
        rom[192] = 16'h0000;
        test_reset;
        test_basic;
        test_sweep;
        test_random;
        test_clr;
        test_hold_overrun;
        test_reset_mid;
`ifdef NCO_GAIN_EN
        test_gain;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
